// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
// Package     : adder_pkg
// Description : Shared types and helpers for the digit-serial adder.
//               State encoding, digit count and digit-counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of digits processed per operation.
    function automatic int calc_ndig(input int width, input int digit);
        return width / digit;
    endfunction

    // One spare bit so the counter never wraps when NDIG is a power of two.
    function automatic int calc_cnt_w(input int width, input int digit);
        return $clog2(width / digit) + 1;
    endfunction

endpackage : adder_pkg
`default_nettype wire

// File: rtl/digit_adder.sv
`default_nettype none
// ============================================================================
// Module      : digit_adder
// Description : Combinational DIGIT-bit ripple-carry adder built from 1-bit
//               full-adder cells.
// Revision    : 1.0 - initial release
// Ports       : i_a, i_b   DIGIT-bit addends
//               i_cin      carry into bit 0
//               o_sum      DIGIT-bit sum
//               o_cout     carry out of the top bit
//               o_c_top    carry into the top bit (signed-overflow detection)
// ============================================================================
module digit_adder #(
    parameter int DIGIT = 8
) (
    input  logic [DIGIT-1:0] i_a,
    input  logic [DIGIT-1:0] i_b,
    input  logic             i_cin,
    output logic [DIGIT-1:0] o_sum,
    output logic             o_cout,
    output logic             o_c_top
);

    logic [DIGIT:0] w_c;

    assign w_c[0] = i_cin;

    for (genvar gi = 0; gi < DIGIT; gi++) begin : g_fa
        assign o_sum[gi]   = i_a[gi] ^ i_b[gi] ^ w_c[gi];
        assign w_c[gi + 1] = (i_a[gi] & i_b[gi]) | (w_c[gi] & (i_a[gi] ^ i_b[gi]));
    end

    assign o_cout  = w_c[DIGIT];
    assign o_c_top = w_c[DIGIT-1];

endmodule : digit_adder
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder
// Description : Multi-cycle digit-serial adder. Adds two WIDTH-bit operands
//               plus carry-in, DIGIT bits per cycle, with a registered carry
//               between digits. Valid/ready handshake on input and output.
//               Optional feature macro: SERIAL_ADD_SUB_EN (adds 'sub' port,
//               sub=1 computes a + ~b + 1 with cin ignored).
// Revision    : 1.0 - initial release
// Ports       : clk, rst             clock, synchronous active-high reset
//               in_valid/in_ready    operand handshake (ready only in IDLE)
//               a, b, cin            operands and carry-in
//               sub                  subtract select (SERIAL_ADD_SUB_EN only)
//               out_valid/out_ready  result handshake
//               sum, cout, ovf       result, carry-out, signed overflow
//               busy                 operation in progress (state != IDLE)
// ============================================================================
module serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int c_ndig  = calc_ndig(WIDTH, DIGIT);
    localparam int c_cnt_w = calc_cnt_w(WIDTH, DIGIT);

    state_t             r_state;
    state_t             w_state_next;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;
    logic               r_cout;
    logic               r_ovf;

    logic [WIDTH-1:0]   w_b_in;
    logic               w_cin_in;
    logic [WIDTH-1:0]   w_a_shift;
    logic [WIDTH-1:0]   w_b_shift;
    logic [WIDTH-1:0]   w_sum_shift;
    logic [DIGIT-1:0]   w_dsum;
    logic               w_dcout;
    logic               w_dctop;
    logic               w_last;

    // Subtraction is folded in at accept time: invert B and force carry-in,
    // so the serial datapath is always a plain adder.
`ifdef SERIAL_ADD_SUB_EN
    assign w_b_in   = sub ? ~b : b;
    assign w_cin_in = sub ? 1'b1 : cin;
`else
    assign w_b_in   = b;
    assign w_cin_in = cin;
`endif

    assign w_last = (r_cnt == c_cnt_w'(c_ndig - 1));

    // The low digit of the operand registers is always the digit in flight;
    // the result shifts in from the top so digit 0 lands at the bottom
    // after NDIG shifts.
    digit_adder #(.DIGIT(DIGIT)) u_digit (
        .i_a     (r_a[DIGIT-1:0]),
        .i_b     (r_b[DIGIT-1:0]),
        .i_cin   (r_carry),
        .o_sum   (w_dsum),
        .o_cout  (w_dcout),
        .o_c_top (w_dctop)
    );

    if (DIGIT < WIDTH) begin : g_shift
        assign w_a_shift   = {{DIGIT{1'b0}}, r_a[WIDTH-1:DIGIT]};
        assign w_b_shift   = {{DIGIT{1'b0}}, r_b[WIDTH-1:DIGIT]};
        assign w_sum_shift = {w_dsum, r_sum[WIDTH-1:DIGIT]};
    end else begin : g_noshift
        assign w_a_shift   = '0;
        assign w_b_shift   = '0;
        assign w_sum_shift = w_dsum;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_state_next = RUN;
            RUN:     if (w_last)    w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default:                w_state_next = IDLE;
        endcase
    end

    // Datapath: operand/result shift registers, carry flop, digit counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= w_b_in;
                        r_carry <= w_cin_in;
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
                    r_a     <= w_a_shift;
                    r_b     <= w_b_shift;
                    r_sum   <= w_sum_shift;
                    r_carry <= w_dcout;
                    r_cnt   <= r_cnt + c_cnt_w'(1);
                    if (w_last) begin
                        r_cout <= w_dcout;
                        r_ovf  <= w_dcout ^ w_dctop;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

endmodule : serial_adder
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder
// Description : Self-checking bench for serial_adder. Runs a 32/8 instance
//               and a 32/32 instance side by side on shared inputs.
//               Honours SERIAL_ADD_SUB_EN for the subtract case.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
`ifdef SERIAL_ADD_SUB_EN
    logic        sub;
`endif

    logic        in_ready_n, out_valid_n, cout_n, ovf_n, busy_n;
    logic [31:0] sum_n;
    logic        in_ready_w, out_valid_w, cout_w, ovf_w, busy_w;
    logic [31:0] sum_w;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(32), .DIGIT(8)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready_n),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef SERIAL_ADD_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid_n),
        .out_ready (out_ready),
        .sum       (sum_n),
        .cout      (cout_n),
        .ovf       (ovf_n),
        .busy      (busy_n)
    );

    serial_adder #(.WIDTH(32), .DIGIT(32)) u_dut_w (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready_w),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef SERIAL_ADD_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid_w),
        .out_ready (out_ready),
        .sum       (sum_w),
        .cout      (cout_w),
        .ovf       (ovf_w),
        .busy      (busy_w)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        else
            n_pass++;
    endtask

    // Issue one operation at a negedge, scramble the inputs after accept,
    // measure latency of both instances and check their results.
    task automatic run_op(input string nm, input logic [31:0] ta, input logic [31:0] tb_,
                          input logic tcin, input logic [31:0] es, input logic ec,
                          input logic eo, input bit hold);
        int  k;
        int  lat_n;
        int  lat_w;
        lat_n = -1;
        lat_w = -1;
        chk({nm, " in_ready"}, 32'(in_ready_n & in_ready_w), 32'd1);
        a         = ta;
        b         = tb_;
        cin       = tcin;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        a        = ~ta;
        b        = ~tb_;
        cin      = ~tcin;
        k        = 1;
        while ((lat_n < 0 || lat_w < 0) && k < 60) begin
            if (lat_n < 0 && out_valid_n) lat_n = k;
            if (lat_w < 0 && out_valid_w) lat_w = k;
            if (lat_n < 0 || lat_w < 0) begin
                @(negedge clk);
                k++;
            end
        end
        chk({nm, " latency d8"},  32'(lat_n), 32'd5);
        chk({nm, " latency d32"}, 32'(lat_w), 32'd2);
        chk({nm, " sum d8"},   sum_n, es);
        chk({nm, " cout d8"},  32'(cout_n), 32'(ec));
        chk({nm, " ovf d8"},   32'(ovf_n), 32'(eo));
        chk({nm, " sum d32"},  sum_w, es);
        chk({nm, " cout d32"}, 32'(cout_w), 32'(ec));
        chk({nm, " ovf d32"},  32'(ovf_w), 32'(eo));
        if (!hold) begin
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
    endtask

    initial begin
        vecs[0] = '{32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 1'b0, 1'b0};
        vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 32'h8000_0000, 1'b0, 1'b1};
        vecs[3] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
        vecs[4] = '{32'h1234_5678, 32'h0FED_CBA9, 1'b0, 32'h2222_2221, 1'b0, 1'b0};
        vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[6] = '{32'h00FF_FFFF, 32'h0000_0001, 1'b1, 32'h0100_0001, 1'b0, 1'b0};
        vecs[7] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
        sub       = 1'b0;
`endif
        @(negedge clk);
        @(negedge clk);
        chk("reset out_valid", 32'(out_valid_n), 32'd0);
        chk("reset sum",       sum_n, 32'd0);
        chk("reset cout",      32'(cout_n), 32'd0);
        chk("reset ovf",       32'(ovf_n), 32'd0);
        chk("reset busy",      32'(busy_n), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post-reset in_ready", 32'(in_ready_n), 32'd1);

        // rst and in_valid together: nothing accepted
        rst      = 1'b1;
        in_valid = 1'b1;
        a        = 32'd5;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("rst+valid busy", 32'(busy_n), 32'd0);
        @(negedge clk);
        chk("rst+valid still idle", 32'(busy_n | busy_w), 32'd0);

        for (int i = 0; i < 8; i++)
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
                   vecs[i].s, vecs[i].co, vecs[i].ov, 1'b0);

        // Stalled output: result held, no new accept while DONE
        run_op("stall", 32'd3, 32'd4, 1'b0, 32'd7, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            a        = 32'd9;
            b        = 32'd0;
            @(negedge clk);
            chk($sformatf("stall%0d out_valid", i), 32'(out_valid_n), 32'd1);
            chk($sformatf("stall%0d in_ready", i),  32'(in_ready_n), 32'd0);
            chk($sformatf("stall%0d sum", i),       sum_n, 32'd7);
        end
        out_ready = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("release out_valid", 32'(out_valid_n), 32'd0);
        chk("release in_ready",  32'(in_ready_n), 32'd1);
        chk("release sum held",  sum_n, 32'd7);

        // Reset on the second RUN cycle aborts the operation
        a        = 32'hFFFF_FFFF;
        b        = 32'h0000_0001;
        cin      = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("abort busy before rst", 32'(busy_n), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort busy",      32'(busy_n), 32'd0);
        chk("abort out_valid", 32'(out_valid_n), 32'd0);
        chk("abort sum",       sum_n, 32'd0);
        chk("abort in_ready",  32'(in_ready_n), 32'd1);
        chk("abort d32 busy",  32'(busy_w), 32'd0);
        run_op("after abort", 32'd10, 32'd20, 1'b0, 32'd30, 1'b0, 1'b0, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
        sub = 1'b1;
        run_op("sub 5-7", 32'd5, 32'd7, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        run_op("sub 7-5", 32'd7, 32'd5, 1'b0, 32'h0000_0002, 1'b1, 1'b0, 1'b0);
        sub = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_serial_adder
`default_nettype wire
